// File: rtl/mulr2_pkg.sv
// Shared types and helpers for the radix-2 multiply-accumulate reconstructor.
package mulr2_pkg;

  localparam int unsigned MAG_W = 64;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mulr2_state_t;

  // Magnitude of a zero-extended operand; neg selects two's-complement negation.
  function automatic logic [MAG_W-1:0] mag_of(input logic [MAG_W-1:0] val,
                                               input logic neg);
    return neg ? (~val + MAG_W'(1)) : val;
  endfunction

endpackage

// File: rtl/mulr2_if.sv
// Request/result bundle between a requester and mulr2_recon.
interface mulr2_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic [WIDTH-1:0] zq;
  logic [WIDTH-1:0] zdivisor;
  logic [WIDTH-1:0] zr;
  logic             sign;
  logic             valid_in;
  logic [WIDTH-1:0] dividend;
  logic             ovf;
  logic             sign_o;
  logic             done;
  logic             free;

  modport master (
    output zq, zdivisor, zr, sign, valid_in,
    input  dividend, ovf, sign_o, done, free
  );

  modport slave (
    input  zq, zdivisor, zr, sign, valid_in,
    output dividend, ovf, sign_o, done, free
  );

endinterface

// File: rtl/mulr2_addsh.sv
// One radix-2 shift-add step: add the multiplicand when the multiplier bit is set.
module mulr2_addsh #(
  parameter int unsigned AW = 64
) (
  input  logic [AW-1:0] acc,
  input  logic [AW-1:0] mcand,
  input  logic          bit_in,
  output logic [AW-1:0] sum_c
);

  // Conditional accumulate
  always_comb begin
    sum_c = acc;
    if (bit_in) sum_c = acc + mcand;
  end

endmodule

// File: rtl/mulr2_recon.sv
// Sequential radix-2 reconstruction: dividend = zq*zdivisor + zr.
// Optional build macro MULR2_EARLY_EXIT_EN ends CALC once the remaining
// multiplier magnitude is zero; results are identical either way.
module mulr2_recon
  import mulr2_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned EXPWIDTH = 5
) (
  input  logic     clk,
  input  logic     rst,
  mulr2_if.slave   bus
);

  localparam int unsigned AW = 2 * WIDTH;
  localparam int unsigned RW = 2 * WIDTH + 1;

`ifdef MULR2_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  mulr2_state_t        state_q, state_d;
  logic [EXPWIDTH-1:0] cnt_q;
  logic [AW-1:0]       mcand_q;
  logic [WIDTH-1:0]    mplier_q;
  logic [AW-1:0]       acc_q;
  logic                prod_neg_q;
  logic                sign_q;
  logic [WIDTH-1:0]    zr_q;
  logic [WIDTH-1:0]    dividend_q;
  logic                ovf_q;
  logic                sign_o_q;
  logic                done_q;
  logic                free_q;

  logic                accept_c;
  logic                calc_last_c;
  logic [WIDTH-1:0]    mag_zq_c;
  logic [WIDTH-1:0]    mag_zd_c;
  logic [AW-1:0]       acc_step_c;
  logic [RW-1:0]       prod_ext_c;
  logic [RW-1:0]       prod_s_c;
  logic [RW-1:0]       zr_ext_c;
  logic [RW-1:0]       exact_c;
  logic                ovf_c;

  assign bus.dividend = dividend_q;
  assign bus.ovf      = ovf_q;
  assign bus.sign_o   = sign_o_q;
  assign bus.done     = done_q;
  assign bus.free     = free_q;

  assign accept_c = (state_q == IDLE) && bus.valid_in;
  assign mag_zq_c = WIDTH'(mag_of(MAG_W'(bus.zq), bus.sign & bus.zq[WIDTH-1]));
  assign mag_zd_c = WIDTH'(mag_of(MAG_W'(bus.zdivisor), bus.sign & bus.zdivisor[WIDTH-1]));

  // Last CALC step: counter exhausted, or (early-exit build) nothing left to add
  assign calc_last_c = (cnt_q == EXPWIDTH'(WIDTH - 1)) ||
                       (EARLY_EXIT && (mplier_q[WIDTH-1:1] == '0));

  mulr2_addsh #(.AW(AW)) u_addsh (
    .acc    (acc_q),
    .mcand  (mcand_q),
    .bit_in (mplier_q[0]),
    .sum_c  (acc_step_c)
  );

  // Fix-up: signed product plus extended addend, then range check
  always_comb begin
    prod_ext_c = {1'b0, acc_q};
    prod_s_c   = prod_neg_q ? (~prod_ext_c + RW'(1)) : prod_ext_c;
    zr_ext_c   = sign_q ? {{(RW - WIDTH){zr_q[WIDTH-1]}}, zr_q}
                        : {{(RW - WIDTH){1'b0}}, zr_q};
    exact_c    = prod_s_c + zr_ext_c;
    if (sign_q) ovf_c = !((&exact_c[RW-1:WIDTH-1]) || !(|exact_c[RW-1:WIDTH-1]));
    else        ovf_c = |exact_c[RW-1:WIDTH];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.valid_in) state_d = CALC;
      CALC:    if (calc_last_c)  state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      free_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      free_q  <= (state_d == IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      prod_neg_q <= 1'b0;
      sign_q     <= 1'b0;
      zr_q       <= '0;
      dividend_q <= '0;
      ovf_q      <= 1'b0;
      sign_o_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept_c) begin
            cnt_q      <= '0;
            mcand_q    <= AW'(mag_zq_c);
            mplier_q   <= mag_zd_c;
            acc_q      <= '0;
            prod_neg_q <= bus.sign & (bus.zq[WIDTH-1] ^ bus.zdivisor[WIDTH-1]);
            sign_q     <= bus.sign;
            zr_q       <= bus.zr;
          end
        end
        CALC: begin
          acc_q    <= acc_step_c;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + EXPWIDTH'(1);
        end
        FIX: begin
          dividend_q <= exact_c[WIDTH-1:0];
          ovf_q      <= ovf_c;
          sign_o_q   <= sign_q & exact_c[RW-1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mulr2_recon.sv
// Directed bench for mulr2_recon with a result scoreboard and latency tracking.
module tb_mulr2_recon;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] dv;
    logic         ovf;
    logic         sg;
    int           dcyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;
  logic done_prev;
  logic [W-1:0] last_dv;
  exp_t sb[$];

  mulr2_if #(.WIDTH(W)) bus ();

  mulr2_recon #(.WIDTH(W), .EXPWIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] q, input logic [W-1:0] d,
                                 input logic [W-1:0] r, input logic s, input int acc_cyc);
    exp_t x;
    logic signed [66:0] a, b, c, e;
    logic [W-1:0] m;
    int hb;
    if (s) begin
      a = {{35{q[W-1]}}, q};
      b = {{35{d[W-1]}}, d};
      c = {{35{r[W-1]}}, r};
    end else begin
      a = {35'd0, q};
      b = {35'd0, d};
      c = {35'd0, r};
    end
    e = a * b + c;
    x.dv  = e[W-1:0];
    x.sg  = s ? e[66] : 1'b0;
    if (s) x.ovf = (e < -67'sd2147483648) || (e > 67'sd2147483647);
    else   x.ovf = (e > 67'sd4294967295);
    m  = (s && d[W-1]) ? (~d + 32'd1) : d;
    hb = 0;
    for (int i = 0; i < W; i++) if (m[i]) hb = i;
`ifdef MULR2_EARLY_EXIT_EN
    x.dcyc = acc_cyc + hb + 2;
`else
    x.dcyc = acc_cyc + W + 1;
`endif
    return x;
  endfunction

  // Result monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      done_prev = 1'b0;
    end else begin
      if (done_prev) begin
        checks++;
        assert (bus.done === 1'b0) else begin
          errors++; $error("FAIL done_pulse_width got done=%b want 0", bus.done);
        end
      end
      if (bus.done === 1'b1) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++; $error("FAIL spurious_done got done=1 want no pulse (cyc %0d)", cyc);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          last_dv = e.dv;
          checks++;
          assert (bus.dividend === e.dv) else begin
            errors++; $error("FAIL dividend got %h want %h", bus.dividend, e.dv);
          end
          checks++;
          assert (bus.ovf === e.ovf) else begin
            errors++; $error("FAIL ovf got %b want %b (dividend %h)", bus.ovf, e.ovf, e.dv);
          end
          checks++;
          assert (bus.sign_o === e.sg) else begin
            errors++; $error("FAIL sign_o got %b want %b (dividend %h)", bus.sign_o, e.sg, e.dv);
          end
          checks++;
          assert (cyc === e.dcyc) else begin
            errors++; $error("FAIL latency got done at cyc %0d want %0d", cyc, e.dcyc);
          end
        end
      end
      done_prev = bus.done;
    end
  end

  // Waits for free, presents a request for one accept edge, records the expectation
  task automatic issue(input logic [W-1:0] q, input logic [W-1:0] d,
                       input logic [W-1:0] r, input logic s, input bit keep);
    int n;
    n = 0;
    bus.zq = q; bus.zdivisor = d; bus.zr = r; bus.sign = s; bus.valid_in = 1'b1;
    while (bus.free !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (bus.free === 1'b1) else begin
      errors++; $error("FAIL free_timeout got free=%b want 1", bus.free);
    end
    sb.push_back(model(q, d, r, s, cyc + 1));
    @(negedge clk);
    if (!keep) bus.valid_in = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    assert (sb.size() == 0) else begin
      errors++; $error("FAIL done_timeout got %0d pending want 0", sb.size());
    end
    sb.delete();
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    assert (bus.dividend === 32'd0) else begin
      errors++; $error("FAIL %s_dividend got %h want 0", tag, bus.dividend);
    end
    checks++;
    assert (bus.ovf === 1'b0 && bus.sign_o === 1'b0) else begin
      errors++; $error("FAIL %s_flags got ovf=%b sign_o=%b want 0/0", tag, bus.ovf, bus.sign_o);
    end
    checks++;
    assert (bus.done === 1'b0 && bus.free === 1'b1) else begin
      errors++; $error("FAIL %s_hs got done=%b free=%b want 0/1", tag, bus.done, bus.free);
    end
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; done_prev = 1'b0; last_dv = '0;
    rst = 1'b1;
    bus.zq = '0; bus.zdivisor = '0; bus.zr = '0; bus.sign = 1'b0; bus.valid_in = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic unsigned and signed cases
    issue(32'd7, 32'd5, 32'd3, 1'b0, 1'b0);                      wait_done();
    issue(32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFE, 1'b1, 1'b0);      wait_done();
    issue(32'h8000_0000, 32'd1, 32'd0, 1'b1, 1'b0);              wait_done();
    // Overflow cases
    issue(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b0);      wait_done();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);      wait_done();
    // Zero operands and extremes
    issue(32'd123, 32'd0, 32'd5, 1'b1, 1'b0);                    wait_done();
    issue(32'd0, 32'd77, 32'hFFFF_FFFF, 1'b0, 1'b0);             wait_done();
    issue(32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1, 1'b0);      wait_done();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0); wait_done();
    issue(32'd9, 32'd1, 32'd0, 1'b0, 1'b0);                      wait_done();
    issue(32'd3, 32'h8000_0000, 32'd1, 1'b0, 1'b0);              wait_done();

    // Results hold while idle
    repeat (4) @(negedge clk);
    checks++;
    assert (bus.dividend === last_dv) else begin
      errors++; $error("FAIL hold got %h want %h", bus.dividend, last_dv);
    end

    // Random mix, small and full-range operands
    for (int k = 0; k < 8; k++) begin
      logic [W-1:0] rq, rd, rr;
      rq = $urandom(); rd = $urandom(); rr = $urandom();
      if (k[0]) begin rq = rq >> 20; rd = rd >> 18; end
      issue(rq, rd, rr, k[1], 1'b0);
      wait_done();
    end

    // valid_in held with new operands through CALC/DONE: second accepted only once free
    issue(32'd1000, 32'h0000_0F00, 32'd7, 1'b0, 1'b1);
    bus.zq = 32'd11; bus.zdivisor = 32'hFFFF_FFF0; bus.zr = 32'd2; bus.sign = 1'b1;
    issue(32'd11, 32'hFFFF_FFF0, 32'd2, 1'b1, 1'b0);
    wait_done();

    // Reset during CALC discards the request
    issue(32'd5, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("midrst");
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'hFFFF_FFFE, 32'd6, 32'd4, 1'b1, 1'b0);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog got no finish want finish before 400000");
    $fatal(1, "watchdog");
  end

endmodule
